// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I-subset core: fetch, decode, execute,
// memory and writeback strobes, trap on illegal encodings or memory timeouts.
module cpu_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  input  logic [31:0] operation,
  input  logic [4:0]  rd,
  input  logic        branch_taken,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [2:0]  imm_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [1:0]  dmem_size,
  input  logic        dmem_ack,
  output logic        instr_done,
  output logic [31:0] instret,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_TRAP    = 3'd6
  } state_t;

  localparam int CNT_LOG = $clog2(MEM_TIMEOUT + 1);
  localparam int TW = (CNT_LOG > 8) ? CNT_LOG : 8;
  localparam logic [TW-1:0] TMO = TW'(MEM_TIMEOUT);

  state_t      state, state_next;
  logic [31:0] op_q;
  logic [4:0]  rd_q;
  logic [TW-1:0] wait_cnt;
  logic [1:0]  cause_d;

  // op_q is one-hot whenever EXECUTE/MEM/WB are reached, so these are exclusive.
  logic is_alui, is_lui, is_auipc, is_load, is_store, is_jal, is_jalr, is_branch;
  logic [1:0] mem_size;
  logic wait_expired;

  assign is_alui   = |(op_q & 32'hF9C0_0000);
  assign is_lui    = op_q[26];
  assign is_auipc  = op_q[25];
  assign is_load   = |op_q[13:11];
  assign is_store  = |op_q[10:8];
  assign is_jal    = op_q[7];
  assign is_jalr   = op_q[6];
  assign is_branch = |op_q[5:0];
  assign mem_size  = (op_q[13] | op_q[10]) ? 2'd0 :
                     (op_q[12] | op_q[9])  ? 2'd1 : 2'd2;
  assign wait_expired = (wait_cnt == TMO);

  assign trap      = (state == S_TRAP);
  assign state_dbg = state;

  // Request/ack: a request is a level held from state entry until the cycle its
  // ack is sampled high; acks seen while the matching request is low are ignored.
  always_comb begin
    state_next = state;
    cause_d    = 2'd0;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    alu_a_sel  = 2'd0;
    alu_b_sel  = 1'b0;
    imm_sel    = 3'd0;
    rf_we      = 1'b0;
    wb_sel     = 2'd0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_size  = 2'd0;
    instr_done = 1'b0;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we      = 1'b1;
          state_next = S_DECODE;
        end else if (wait_expired) begin
          state_next = S_TRAP;
          cause_d    = 2'd2;
        end
      end
      S_DECODE: begin
        if (!$onehot(operation)) begin
          state_next = S_TRAP;
          cause_d    = 2'd1;
        end else begin
          state_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_next = S_WB;
        if (is_branch) begin
          imm_sel    = 3'd2;
          pc_we      = 1'b1;
          pc_src     = branch_taken ? 2'd1 : 2'd0;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end else if (is_load || is_store) begin
          alu_b_sel  = 1'b1;
          imm_sel    = is_store ? 3'd1 : 3'd0;
          state_next = S_MEM;
        end else if (is_lui) begin
          alu_a_sel = 2'd2;
          imm_sel   = 3'd3;
        end else if (is_auipc) begin
          alu_a_sel = 2'd1;
          imm_sel   = 3'd3;
        end else if (is_alui) begin
          alu_b_sel = 1'b1;
        end else if (is_jal) begin
          imm_sel = 3'd4;
        end
      end
      S_MEM: begin
        dmem_req  = 1'b1;
        dmem_we   = is_store;
        dmem_size = mem_size;
        if (dmem_ack) begin
          if (is_store) begin
            pc_we      = 1'b1;
            instr_done = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (wait_expired) begin
          state_next = S_TRAP;
          cause_d    = 2'd3;
        end
      end
      S_WB: begin
        rf_we      = (rd_q != 5'd0);
        wb_sel     = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
        pc_we      = 1'b1;
        pc_src     = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: state_next = S_TRAP;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= 32'd0;
      rd_q       <= 5'd0;
      wait_cnt   <= '0;
      trap_cause <= 2'd0;
      instret    <= 32'd0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) begin
        op_q <= operation;
        rd_q <= rd;
      end
      // Any state other than a waiting FETCH/MEM clears the count, so entry sees zero.
      if ((state == S_FETCH && !imem_ack) || (state == S_MEM && !dmem_ack))
        wait_cnt <= wait_cnt + TW'(1);
      else
        wait_cnt <= '0;
      if (state != S_TRAP && state_next == S_TRAP)
        trap_cause <= cause_d;
      if (instr_done)
        instret <= instret + 32'd1;
    end
  end

endmodule
